game_state_ctrl: RTL and testbench

- Registered owner of the 134-bit Sokoban game state.
- Loads a level from the level ROM path and commits results from the combinational man-move stage.
- Keeps a bounded undo history, a step counter and win status.
- Sits directly downstream of the move logic; its game_state output feeds back into that logic's input and into the VGA renderer.

---
 rtl/game_state_ctrl.sv | 140 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// ============================================================================
// game_state_ctrl : registered Sokoban game state with level load, undo ring,
//                   step counter and win detection.  Rev 1.0
// ============================================================================
`default_nettype none

module game_state_ctrl #(
   parameter int UNDO_DEPTH = 8,
   parameter int STEP_W     = 10
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            level_valid,
   output logic                            level_ready,
   input  logic [133:0]                    level_state,
   input  logic [63:0]                     level_target,
   input  logic                            move_req,
   input  logic [133:0]                    move_state,
   input  logic                            move_ok,
   input  logic                            undo_req,
   output logic [133:0]                    game_state,
   output logic [63:0]                     target,
   output logic [STEP_W-1:0]               steps,
   output logic [$clog2(UNDO_DEPTH):0]     undo_cnt,
   output logic                            win,
   output logic                            move_rej,
   output logic                            play
);

   localparam int c_PTR_W = $clog2(UNDO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WON  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [133:0]         gs_q, gs_d;
   logic [63:0]          tgt_q, tgt_d;
   logic [STEP_W-1:0]    steps_q, steps_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d;
   logic [c_PTR_W-1:0]   ptr_q, ptr_d;
   logic                 rej_q, rej_d;
   logic                 win_q, play_q;
   logic [133:0]         ring_q [UNDO_DEPTH];

   logic                 w_load, w_undo, w_move, w_push;
   logic [c_PTR_W-1:0]   w_ptr_prev;
   logic [133:0]         w_ring_rd;

   function automatic logic win_of(input logic [133:0] s, input logic [63:0] t);
      return (t != 64'd0) && ((s[69:6] & t) == t);
   endfunction

   assign w_ptr_prev = ptr_q - c_PTR_W'(1);
   assign w_ring_rd  = ring_q[w_ptr_prev];
   assign w_load     = level_valid & level_ready;
   assign w_undo     = undo_req & (state_q != ST_IDLE) & (cnt_q != '0);
   assign w_move     = move_req & (state_q == ST_PLAY);

   always_comb begin
      state_d = state_q;
      gs_d    = gs_q;
      tgt_d   = tgt_q;
      steps_d = steps_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      rej_d   = 1'b0;
      w_push  = 1'b0;
      if (w_load) begin
         gs_d    = level_state;
         tgt_d   = level_target;
         steps_d = '0;
         cnt_d   = '0;
         ptr_d   = '0;
         state_d = win_of(level_state, level_target) ? ST_WON : ST_PLAY;
      end else if (w_undo) begin
         ptr_d   = w_ptr_prev;
         gs_d    = w_ring_rd;
         cnt_d   = cnt_q - c_CNT_W'(1);
         if (steps_q != '0) steps_d = steps_q - STEP_W'(1);
         state_d = win_of(w_ring_rd, tgt_q) ? ST_WON : ST_PLAY;
      end else if (w_move) begin
         if (move_ok) begin
            // Ring is a circular buffer: a full ring silently drops its oldest entry.
            w_push  = 1'b1;
            ptr_d   = ptr_q + c_PTR_W'(1);
            if (cnt_q != c_CNT_W'(UNDO_DEPTH)) cnt_d = cnt_q + c_CNT_W'(1);
            gs_d    = move_state;
            if (steps_q != '1) steps_d = steps_q + STEP_W'(1);
            state_d = win_of(move_state, tgt_q) ? ST_WON : ST_PLAY;
         end else begin
            rej_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gs_q    <= '0;
         tgt_q   <= '0;
         steps_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         rej_q   <= 1'b0;
         win_q   <= 1'b0;
         play_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gs_q    <= gs_d;
         tgt_q   <= tgt_d;
         steps_q <= steps_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         rej_q   <= rej_d;
         win_q   <= (state_d == ST_WON);
         play_q  <= (state_d == ST_PLAY);
      end
   end

   // History contents need no reset; only entries counted by cnt_q are read.
   always_ff @(posedge clk) begin
      if (!rst && w_push) ring_q[ptr_q] <= gs_q;
   end

   assign level_ready = 1'b1;
   assign game_state  = gs_q;
   assign target      = tgt_q;
   assign steps       = steps_q;
   assign undo_cnt    = cnt_q;
   assign win         = win_q;
   assign move_rej    = rej_q;
   assign play        = play_q;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// ============================================================================
// tb_game_state_ctrl : directed self-checking bench for game_state_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_game_state_ctrl;

   logic          clk = 1'b0;
   logic          rst;
   logic          level_valid;
   logic          level_ready;
   logic [133:0]  level_state;
   logic [63:0]   level_target;
   logic          move_req;
   logic [133:0]  move_state;
   logic          move_ok;
   logic          undo_req;
   logic [133:0]  game_state;
   logic [63:0]   target;
   logic [9:0]    steps;
   logic [3:0]    undo_cnt;
   logic          win;
   logic          move_rej;
   logic          play;

   int checks   = 0;
   int failures = 0;

   logic [133:0] st [0:10];
   logic [133:0] lvl, lvl2, wst, wlvl;
   logic [63:0]  tgt;

   always #5 clk = ~clk;

   game_state_ctrl #(.UNDO_DEPTH(8), .STEP_W(10)) dut (
      .clk(clk), .rst(rst),
      .level_valid(level_valid), .level_ready(level_ready),
      .level_state(level_state), .level_target(level_target),
      .move_req(move_req), .move_state(move_state), .move_ok(move_ok),
      .undo_req(undo_req),
      .game_state(game_state), .target(target), .steps(steps),
      .undo_cnt(undo_cnt), .win(win), .move_rej(move_rej), .play(play)
   );

   function automatic logic [133:0] mk(input logic [63:0] box, input logic [5:0] man);
      return {64'hF0F0_0FF0_A5A5_5A5A, box, man};
   endfunction

   task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      level_valid = 1'b0;
      move_req    = 1'b0;
      move_ok     = 1'b0;
      undo_req    = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      level_state  = '0;
      level_target = '0;
      move_state   = '0;
      tgt = 64'd1 << 27;
      lvl = mk(64'd1 << 18, 6'o22);
      for (int k = 0; k <= 10; k++)
         st[k] = (k == 0) ? lvl : mk((64'(k) << 40) | (64'd1 << 18), 6'(k));
      wst  = mk((64'd1 << 27) | (64'd1 << 18), 6'o11);
      lvl2 = mk(64'd1 << 5, 6'o07);
      wlvl = mk(64'd1 << 27, 6'o00);

      // Reset state
      tick(); tick();
      chk("rst_gs", game_state, 134'd0);
      chk("rst_tgt", 134'(target), 134'd0);
      chk("rst_steps", 134'(steps), 134'd0);
      chk("rst_cnt", 134'(undo_cnt), 134'd0);
      chk("rst_flags", 134'({win, move_rej, play}), 134'd0);
      chk("rst_ready", 134'(level_ready), 134'd1);
      rst = 1'b0;

      // Load a level
      level_valid = 1'b1; level_state = lvl; level_target = tgt;
      tick(); idle_inputs();
      chk("load_gs", game_state, lvl);
      chk("load_tgt", 134'(target), 134'(tgt));
      chk("load_flags", 134'({win, play, move_rej}), 134'b010);
      chk("load_steps", 134'(steps), 134'd0);
      chk("load_cnt", 134'(undo_cnt), 134'd0);

      // Accepted move then undo
      move_req = 1'b1; move_ok = 1'b1; move_state = mk(64'd1 << 18, 6'o23);
      tick(); idle_inputs();
      chk("mv_man", 134'(game_state[5:0]), 134'(6'o23));
      chk("mv_steps", 134'(steps), 134'd1);
      chk("mv_cnt", 134'(undo_cnt), 134'd1);
      undo_req = 1'b1;
      tick(); idle_inputs();
      chk("undo_gs", game_state, lvl);
      chk("undo_steps", 134'(steps), 134'd0);
      chk("undo_cnt", 134'(undo_cnt), 134'd0);

      // Refused move: one-cycle move_rej, no state change
      move_req = 1'b1; move_ok = 1'b0; move_state = st[5];
      tick(); idle_inputs();
      chk("rej_gs", game_state, lvl);
      chk("rej_steps", 134'(steps), 134'd0);
      chk("rej_pulse", 134'(move_rej), 134'd1);
      tick();
      chk("rej_clear", 134'(move_rej), 134'd0);

      // Ten accepted moves overflow the 8-entry ring
      for (int k = 1; k <= 10; k++) begin
         move_req = 1'b1; move_ok = 1'b1; move_state = st[k];
         tick();
      end
      idle_inputs();
      chk("ten_gs", game_state, st[10]);
      chk("ten_steps", 134'(steps), 134'd10);
      chk("ten_cnt", 134'(undo_cnt), 134'd8);
      for (int i = 1; i <= 8; i++) begin
         undo_req = 1'b1;
         tick();
         chk($sformatf("ring_undo%0d", i), game_state, st[10 - i]);
      end
      chk("ring_steps", 134'(steps), 134'd2);
      chk("ring_cnt", 134'(undo_cnt), 134'd0);
      tick(); idle_inputs();
      chk("ring_extra_gs", game_state, st[2]);
      chk("ring_extra_steps", 134'(steps), 134'd2);

      // Move that solves the level
      move_req = 1'b1; move_ok = 1'b1; move_state = wst;
      tick(); idle_inputs();
      chk("win_gs", game_state, wst);
      chk("win_flags", 134'({win, play}), 134'b10);
      chk("win_steps", 134'(steps), 134'd3);
      move_req = 1'b1; move_ok = 1'b1; move_state = st[7];
      tick(); idle_inputs();
      chk("won_ignore_gs", game_state, wst);
      chk("won_ignore_misc", 134'({steps, move_rej, win}), 134'({10'd3, 1'b0, 1'b1}));
      undo_req = 1'b1;
      tick(); idle_inputs();
      chk("won_undo_gs", game_state, st[2]);
      chk("won_undo_flags", 134'({win, play}), 134'b01);
      chk("won_undo_steps", 134'(steps), 134'd2);

      // Load wins on arrival
      level_valid = 1'b1; level_state = wlvl; level_target = tgt;
      tick(); idle_inputs();
      chk("load_win", 134'({win, play, steps}), 134'({1'b1, 1'b0, 10'd0}));

      // Load beats undo and move in the same cycle
      move_req = 1'b1; move_ok = 1'b1; move_state = st[3];
      tick(); idle_inputs();
      chk("pre_combo_gs", game_state, wlvl);
      level_valid = 1'b1; level_state = lvl; level_target = tgt;
      tick(); idle_inputs();
      move_req = 1'b1; move_ok = 1'b1; move_state = st[4];
      tick(); idle_inputs();
      chk("pre_combo_cnt", 134'(undo_cnt), 134'd1);
      level_valid = 1'b1; level_state = lvl2; level_target = tgt;
      move_req = 1'b1; move_ok = 1'b0; move_state = st[6]; undo_req = 1'b1;
      tick(); idle_inputs();
      chk("combo_gs", game_state, lvl2);
      chk("combo_misc", 134'({steps, undo_cnt, play, win}), 134'({10'd0, 4'd0, 1'b1, 1'b0}));
      tick();
      chk("combo_norej", 134'(move_rej), 134'd0);

      // Reset mid-play
      move_req = 1'b1; move_ok = 1'b1; move_state = st[8];
      tick(); idle_inputs();
      rst = 1'b1;
      tick();
      chk("mid_rst_gs", game_state, 134'd0);
      chk("mid_rst_misc", 134'({target, steps, undo_cnt, win, move_rej, play}), 134'd0);
      chk("mid_rst_ready", 134'(level_ready), 134'd1);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
